// File: rtl/parking_slot_scheduler.sv
// Parking-lot slot scheduler: keeps the lot clock, allocates/releases slots and
// sequences the shared time subtractor between entry and exit gate events.
module parking_slot_scheduler #(
  parameter int SLOTS = 4,
  parameter int SID_W = 2,
  parameter int TW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [SID_W-1:0] exit_slot,
  output logic             entry_ack,
  output logic [SID_W-1:0] entry_slot,
  output logic             entry_full,
  output logic             exit_done,
  output logic             exit_err,
  output logic [TW-1:0]    duration,
  output logic [TW-1:0]    now,
  output logic [SID_W:0]   free_count
);

  localparam int NS = 1 << SID_W;

  typedef enum logic [1:0] {IDLE, ENTRY, EX_CALC, EX_DONE} state_t;

  state_t           state, state_nxt;
  logic [NS-1:0]    occupied;
  logic [TW-1:0]    stamp [NS];
  logic [TW-1:0]    t_out_p0, t_in_p0;
  logic [SID_W-1:0] slot_p0;
  logic             free_found;
  logic [SID_W-1:0] free_idx;
  logic             exit_ok;
  logic             do_alloc, do_full, do_err, do_latch, do_done;

  // Modular difference; the borrow out of the top bit is intentionally dropped.
  function automatic logic [TW-1:0] sub_wrap(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[TW-1:0];
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_found = 1'b1;
        free_idx   = SID_W'(i);
      end
    end
  end

  assign exit_ok = (int'(exit_slot) < SLOTS) && occupied[exit_slot];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_alloc  = 1'b0;
    do_full   = 1'b0;
    do_err    = 1'b0;
    do_latch  = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE: begin
        if (exit_req)       state_nxt = EX_CALC;
        else if (entry_req) state_nxt = ENTRY;
      end
      ENTRY: begin
        state_nxt = IDLE;
        do_alloc  = free_found;
        do_full   = !free_found;
      end
      EX_CALC: begin
        if (exit_ok) begin
          state_nxt = EX_DONE;
          do_latch  = 1'b1;
        end else begin
          state_nxt = IDLE;
          do_err    = 1'b1;
        end
      end
      EX_DONE: begin
        state_nxt = IDLE;
        do_done   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now        <= '0;
      occupied   <= '0;
      free_count <= (SID_W + 1)'(SLOTS);
      entry_ack  <= 1'b0;
      entry_full <= 1'b0;
      exit_err   <= 1'b0;
      exit_done  <= 1'b0;
      entry_slot <= '0;
      duration   <= '0;
    end else begin
      if (tick) now <= now + TW'(1);
      entry_ack  <= do_alloc;
      entry_full <= do_full;
      exit_err   <= do_err;
      exit_done  <= do_done;
      if (do_alloc) begin
        occupied[free_idx] <= 1'b1;
        entry_slot         <= free_idx;
        free_count         <= free_count - (SID_W + 1)'(1);
      end
      if (do_done) begin
        occupied[slot_p0] <= 1'b0;
        free_count        <= free_count + (SID_W + 1)'(1);
        duration          <= sub_wrap(t_out_p0, t_in_p0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) stamp[i] <= '0;
    end else if (do_alloc) begin
      stamp[free_idx] <= now;
    end
  end

  // Stage p0: subtractor operands captured on leaving EX_CALC, so a tick in
  // that same cycle is counted in now but not in the duration.
  always_ff @(posedge clk) begin
    if (do_latch) begin
      t_out_p0 <= now;
      t_in_p0  <= stamp[exit_slot];
      slot_p0  <= exit_slot;
    end
  end

endmodule
